// File: rtl/id_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl_if
//  Bundle between the ID-stage hazard controller and the pipeline around it.
//  Inputs to the controller: ID source registers and their use flags, EX
//  destination / load flag, branch mispredict and the global freeze.
//  Outputs from the controller: PC and IF/ID write enables, IF/ID flush,
//  ID/EX bubble, FSM state and the two saturating statistics counters.
//  master : the pipeline side (drives decode/EX info, observes controls)
//  slave  : the hazard controller
// ---------------------------------------------------------------------------
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_mispredict;
  logic             ext_hold;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_mem_read, ex_mispredict, ext_hold,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
    input  state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_mem_read, ex_mispredict, ext_hold,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
    output state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//  Stall/flush sequencer for the decode stage. Detects load-use hazards
//  against a load in EX, holds PC and IF/ID for LOAD_STALL_CYCLES bubbles,
//  and flushes IF/ID plus bubbles ID/EX for FLUSH_CYCLES after a mispredict.
//  Control outputs are combinational from the registered state and the
//  current inputs, so a hazard is answered in the cycle it appears.
//  Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous reset, active HIGH (historical name)
//   hz   : slave side of id_hazard_ctrl_if (hazard inputs, pipeline
//          controls, state_o, stall_cnt, flush_cnt)
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic            clk,
  input  logic            rstn,
  id_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // One down-counter serves both multi-cycle states; size it for the longer.
  localparam int MAX_LEN = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] LSTALL_LOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LOAD  = CW'(FLUSH_CYCLES - 1);

  logic [1:0]       state_r, state_nx_s, state_dec_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_nx_s;
  logic [CNT_W-1:0] flush_cnt_r, flush_nx_s;
  logic             hazard_s;
  logic             pc_we_s, if_id_we_s, flush_s, bubble_s;

  // Statistics never wrap: stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Load-use hazard detect and state decode (encoding 3 behaves as RUN).
  always_comb begin
    hazard_s = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
    if ((state_r == ST_LSTALL) || (state_r == ST_FLUSH)) begin
      state_dec_s = state_r;
    end else begin
      state_dec_s = ST_RUN;
    end
  end

  // State, sequencing counter and statistics registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r     <= ST_RUN;
      cnt_r       <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      stall_cnt_r <= stall_nx_s;
      flush_cnt_r <= flush_nx_s;
    end
  end

  // Next-state logic: freeze > mispredict > per-state sequencing.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    stall_nx_s = stall_cnt_r;
    flush_nx_s = flush_cnt_r;
    if (hz.ext_hold) begin
      state_nx_s = state_r;
    end else if (hz.ex_mispredict) begin
      // Same handling from every state; also aborts a load stall.
      flush_nx_s = sat_inc(flush_cnt_r);
      if (FLUSH_CYCLES > 1) begin
        state_nx_s = ST_FLUSH;
        cnt_nx_s   = FLUSH_LOAD;
      end else begin
        state_nx_s = ST_RUN;
        cnt_nx_s   = '0;
      end
    end else begin
      case (state_dec_s)
        ST_RUN: begin
          if (hazard_s) begin
            stall_nx_s = sat_inc(stall_cnt_r);
            if (LOAD_STALL_CYCLES > 1) begin
              state_nx_s = ST_LSTALL;
              cnt_nx_s   = LSTALL_LOAD;
            end else begin
              state_nx_s = ST_RUN;
              cnt_nx_s   = '0;
            end
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_LSTALL: begin
          // Hazard is deliberately not re-evaluated while stalling.
          stall_nx_s = sat_inc(stall_cnt_r);
          if (cnt_r <= CW'(1)) begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = ST_LSTALL;
            cnt_nx_s   = cnt_r - CW'(1);
          end
        end
        ST_FLUSH: begin
          if (cnt_r <= CW'(1)) begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = ST_FLUSH;
            cnt_nx_s   = cnt_r - CW'(1);
          end
        end
        default: begin
          state_nx_s = ST_RUN;
          cnt_nx_s   = '0;
        end
      endcase
    end
  end

  // Pipeline control outputs from state plus live inputs.
  always_comb begin
    pc_we_s    = 1'b0;
    if_id_we_s = 1'b0;
    flush_s    = 1'b0;
    bubble_s   = 1'b0;
    if (rstn) begin
      bubble_s = 1'b1;
    end else if (hz.ext_hold) begin
      bubble_s = 1'b0;
    end else if (hz.ex_mispredict || (state_dec_s == ST_FLUSH)) begin
      pc_we_s    = 1'b1;
      if_id_we_s = 1'b1;
      flush_s    = 1'b1;
      bubble_s   = 1'b1;
    end else begin
      case (state_dec_s)
        ST_RUN: begin
          if (hazard_s) begin
            bubble_s = 1'b1;
          end else begin
            pc_we_s    = 1'b1;
            if_id_we_s = 1'b1;
          end
        end
        ST_LSTALL: begin
          bubble_s = 1'b1;
        end
        default: begin
          pc_we_s    = 1'b1;
          if_id_we_s = 1'b1;
        end
      endcase
    end
  end

  assign hz.pc_write_en    = pc_we_s;
  assign hz.if_id_write_en = if_id_we_s;
  assign hz.if_id_flush    = flush_s;
  assign hz.id_ex_bubble   = bubble_s;
  assign hz.state_o        = state_r;
  assign hz.stall_cnt      = stall_cnt_r;
  assign hz.flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
//  Drives three controllers with shared stimulus:
//   d0: LOAD_STALL_CYCLES=2 FLUSH_CYCLES=2 CNT_W=16
//   d1: LOAD_STALL_CYCLES=3 FLUSH_CYCLES=2 CNT_W=16
//   d2: LOAD_STALL_CYCLES=2 FLUSH_CYCLES=1 CNT_W=2
//  A reference model pushes expected outputs into a scoreboard queue each
//  cycle; DUT outputs are popped and compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;

  logic       clk;
  logic       rstn;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, mp, hold;

  int n_chk = 0;
  int n_err = 0;

  id_hazard_ctrl_if #(.CNT_W(16)) if_a ();
  id_hazard_ctrl_if #(.CNT_W(16)) if_b ();
  id_hazard_ctrl_if #(.CNT_W(2))  if_c ();

  assign if_a.id_rs1 = rs1;  assign if_b.id_rs1 = rs1;  assign if_c.id_rs1 = rs1;
  assign if_a.id_rs2 = rs2;  assign if_b.id_rs2 = rs2;  assign if_c.id_rs2 = rs2;
  assign if_a.id_rs1_used = u1;  assign if_b.id_rs1_used = u1;  assign if_c.id_rs1_used = u1;
  assign if_a.id_rs2_used = u2;  assign if_b.id_rs2_used = u2;  assign if_c.id_rs2_used = u2;
  assign if_a.ex_rd = rd;  assign if_b.ex_rd = rd;  assign if_c.ex_rd = rd;
  assign if_a.ex_mem_read = mr;  assign if_b.ex_mem_read = mr;  assign if_c.ex_mem_read = mr;
  assign if_a.ex_mispredict = mp;  assign if_b.ex_mispredict = mp;  assign if_c.ex_mispredict = mp;
  assign if_a.ext_hold = hold;  assign if_b.ext_hold = hold;  assign if_c.ext_hold = hold;

  id_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn), .hz(if_a.slave));
  id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
    .clk(clk), .rstn(rstn), .hz(if_b.slave));
  id_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(2)) dut_c (
    .clk(clk), .rstn(rstn), .hz(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state per DUT.
  int p_l[3];
  int p_f[3];
  int p_max[3];
  int m_st[3];
  int m_cnt[3];
  int m_sc[3];
  int m_fc[3];

  typedef struct {
    int         d;
    logic [5:0] ctl;
    int         sc;
    int         fc;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic m_hazard();
    return mr && (rd != 5'd0) && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
  endfunction

  // Expected {pc_we, if_id_we, flush, bubble, state[1:0]}.
  function automatic logic [5:0] m_ctl(input int d);
    logic [1:0] s;
    s = 2'(m_st[d]);
    if (rstn)            return {4'b0001, 2'd0};
    if (hold)            return {4'b0000, s};
    if (m_st[d] == 2 || mp) return {4'b1111, s};
    if (m_st[d] == 1)    return {4'b0001, s};
    if (m_hazard())      return {4'b0001, s};
    return {4'b1100, s};
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      m_st[d] = 0; m_cnt[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic m_update();
    logic hz;
    hz = m_hazard();
    for (int d = 0; d < 3; d++) begin
      if (rstn) begin
        m_st[d] = 0; m_cnt[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      end else if (!hold) begin
        if (mp) begin
          if (m_fc[d] < p_max[d]) m_fc[d]++;
          m_st[d]  = (p_f[d] > 1) ? 2 : 0;
          m_cnt[d] = p_f[d] - 1;
        end else if (m_st[d] == 0 && hz) begin
          if (m_sc[d] < p_max[d]) m_sc[d]++;
          m_st[d]  = (p_l[d] > 1) ? 1 : 0;
          m_cnt[d] = p_l[d] - 1;
        end else if (m_st[d] == 1) begin
          if (m_sc[d] < p_max[d]) m_sc[d]++;
          m_cnt[d]--;
          if (m_cnt[d] == 0) m_st[d] = 0;
        end else if (m_st[d] == 2) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) m_st[d] = 0;
        end
      end
    end
  endtask

  function automatic logic [5:0] dut_ctl(input int d);
    case (d)
      0: return {if_a.pc_write_en, if_a.if_id_write_en, if_a.if_id_flush, if_a.id_ex_bubble, if_a.state_o};
      1: return {if_b.pc_write_en, if_b.if_id_write_en, if_b.if_id_flush, if_b.id_ex_bubble, if_b.state_o};
      default: return {if_c.pc_write_en, if_c.if_id_write_en, if_c.if_id_flush, if_c.id_ex_bubble, if_c.state_o};
    endcase
  endfunction

  function automatic int dut_sc(input int d);
    case (d)
      0: return int'(if_a.stall_cnt);
      1: return int'(if_b.stall_cnt);
      default: return int'(if_c.stall_cnt);
    endcase
  endfunction

  function automatic int dut_fc(input int d);
    case (d)
      0: return int'(if_a.flush_cnt);
      1: return int'(if_b.flush_cnt);
      default: return int'(if_c.flush_cnt);
    endcase
  endfunction

  task automatic push_all();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.d = d; e.ctl = m_ctl(d); e.sc = m_sc[d]; e.fc = m_fc[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s_d%0d_ctl", tag, e.d), int'(dut_ctl(e.d)), int'(e.ctl));
      check_val($sformatf("%s_d%0d_stall", tag, e.d), dut_sc(e.d), e.sc);
      check_val($sformatf("%s_d%0d_flush", tag, e.d), dut_fc(e.d), e.fc);
    end
  endtask

  // One clock: drive at negedge, compare 1 time unit later, advance model at posedge.
  task automatic cycle(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                       input logic b1, input logic b2, input logic [4:0] r,
                       input logic l, input logic m, input logic h);
    rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = r; mr = l; mp = m; hold = h;
    #1;
    push_all();
    drain(tag);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b1;
    #1;
    m_reset();
    push_all();
    drain(tag);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    p_l   = '{2, 3, 2};
    p_f   = '{2, 2, 1};
    p_max = '{65535, 65535, 3};
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    u1 = 1'b0; u2 = 1'b0; mr = 1'b0; mp = 1'b0; hold = 1'b0;
    rstn = 1'b1;
    m_reset();
    do_reset("reset");
    idle("run", 1);

    // Load-use on rs2 with LOAD_STALL_CYCLES=2: two bubble cycles.
    cycle("lu", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle("lu_st", 3);
    check_val("a_stall_after_loaduse", int'(if_a.stall_cnt), 2);

    // ex_rd = 0 and an unused rs1 never stall.
    cycle("rd0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("rs1_unused", 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check_val("a_no_extra_stall", int'(if_a.stall_cnt), 2);

    // Mispredict with FLUSH_CYCLES=2: state 0 -> 2 -> 0.
    cycle("mp", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_val("a_state_flush", int'(if_a.state_o), 2);
    idle("mp_fl", 2);
    check_val("a_flush_cnt", int'(if_a.flush_cnt), 1);

    // Mispredict on first LSTALL cycle of the 3-cycle stall.
    cycle("lu3", 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle("lu3_mp", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_val("b_state_flush_wins", int'(if_b.state_o), 2);
    idle("lu3_after", 3);

    // Freeze for 3 cycles mid-FLUSH, then let the flush finish.
    cycle("hold_mp", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("hold", 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
    idle("hold_rel", 2);

    // Async reset mid-FLUSH.
    cycle("rst_mp", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    do_reset("rst_mid");
    idle("rst_after", 1);

    // Five load-use hazards: 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      cycle("sat", 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
      idle("sat_st", 3);
    end
    check_val("c_stall_saturated", int'(if_c.stall_cnt), 3);

    // Random mix with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
